// File: rtl/vliw_processor_if.sv
// Bench-facing bus of the VLIW core: instruction-memory load port,
// register-file debug read, and run status.
interface vliw_processor_if #(
  parameter int IMEM_AW = 8
);
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [319:0]       imem_wdata;
  logic [4:0]         dbg_raddr;
  logic [31:0]        dbg_rdata;
  logic [IMEM_AW-1:0] pc;
  logic               halted;

  modport master (
    output imem_we, imem_waddr, imem_wdata, dbg_raddr,
    input  dbg_rdata, pc, halted
  );

  modport slave (
    input  imem_we, imem_waddr, imem_wdata, dbg_raddr,
    output dbg_rdata, pc, halted
  );
endinterface

// File: rtl/vliw_processor.sv
// Single-cycle 10-slot VLIW core: every slot of the bundle at pc executes in
// parallel on pre-bundle state, and all results commit on the next edge.
module vliw_processor #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  vliw_processor_if.slave  bus
);
  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);
  localparam int NSLOTS  = 10;

  localparam logic [4:0] OP_ADD  = 5'b01001;
  localparam logic [4:0] OP_SUB  = 5'b01010;
  localparam logic [4:0] OP_AND  = 5'b01011;
  localparam logic [4:0] OP_OR   = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_SLL  = 5'b01110;
  localparam logic [4:0] OP_SRL  = 5'b01111;
  localparam logic [4:0] OP_SLT  = 5'b10000;
  localparam logic [4:0] OP_LI   = 5'b10100;
  localparam logic [4:0] OP_ADDI = 5'b10101;
  localparam logic [4:0] OP_LW   = 5'b11000;
  localparam logic [4:0] OP_SW   = 5'b11001;
  localparam logic [4:0] OP_JMP  = 5'b11110;
  localparam logic [4:0] OP_HALT = 5'b11111;

  logic [319:0]       imem [IMEM_DEPTH];
  logic [31:0]        dmem [DMEM_DEPTH];
  logic [31:0]        regs_reg  [32];
  logic [31:0]        regs_next [32];
  logic [IMEM_AW-1:0] pc_reg, pc_next;
  logic               halted_reg, halted_next;
  logic [319:0]       bundle;

  logic [31:0]        res     [NSLOTS];
  logic [4:0]         rd_f    [NSLOTS];
  logic [DMEM_AW-1:0] sw_addr [NSLOTS];
  logic [31:0]        sw_data [NSLOTS];
  logic [IMEM_AW-1:0] jmp_tgt [NSLOTS];
  logic [NSLOTS-1:0]  wen, sw_en, jmp_en, halt_en;

  // Fetch is combinational, so a write to the fetched address shows up next cycle.
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      imem[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  assign bundle = imem[pc_reg];

  generate
    for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_slot
      logic [31:0]        slot, a, b, imm22, imm17, ea;
      logic [4:0]         op;
      logic [DMEM_AW-1:0] ea_idx;
      logic [31:0]        s_res;
      logic               s_wen, s_sw, s_jmp, s_halt;
      logic               unused_ea;

      assign slot      = bundle[32*gi +: 32];
      assign op        = slot[31:27];
      assign a         = regs_reg[slot[21:17]];
      assign b         = regs_reg[slot[16:12]];
      assign imm22     = {{10{slot[21]}}, slot[21:0]};
      assign imm17     = {{15{slot[16]}}, slot[16:0]};
      assign ea        = a + imm17;
      assign ea_idx    = ea[DMEM_AW-1:0];
      assign unused_ea = ^ea[31:DMEM_AW];

      always_comb begin
        s_res  = '0;
        s_wen  = 1'b0;
        s_sw   = 1'b0;
        s_jmp  = 1'b0;
        s_halt = 1'b0;
        case (op)
          OP_ADD:  begin s_res = a + b;           s_wen = 1'b1; end
          OP_SUB:  begin s_res = a - b;           s_wen = 1'b1; end
          OP_AND:  begin s_res = a & b;           s_wen = 1'b1; end
          OP_OR:   begin s_res = a | b;           s_wen = 1'b1; end
          OP_XOR:  begin s_res = a ^ b;           s_wen = 1'b1; end
          OP_SLL:  begin s_res = a << b[4:0];     s_wen = 1'b1; end
          OP_SRL:  begin s_res = a >> b[4:0];     s_wen = 1'b1; end
          OP_SLT:  begin
            s_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            s_wen = 1'b1;
          end
          OP_LI:   begin s_res = imm22;           s_wen = 1'b1; end
          OP_ADDI: begin s_res = ea;              s_wen = 1'b1; end
          OP_LW:   begin s_res = dmem[ea_idx];    s_wen = 1'b1; end
          OP_SW:   s_sw   = 1'b1;
          OP_JMP:  s_jmp  = 1'b1;
          OP_HALT: s_halt = 1'b1;
          default: ;
        endcase
      end

      assign res[gi]     = s_res;
      assign wen[gi]     = s_wen;
      assign sw_en[gi]   = s_sw;
      assign jmp_en[gi]  = s_jmp;
      assign halt_en[gi] = s_halt;
      assign rd_f[gi]    = slot[26:22];
      assign sw_addr[gi] = ea_idx;
      assign sw_data[gi] = regs_reg[slot[26:22]];
      assign jmp_tgt[gi] = slot[IMEM_AW-1:0];
    end
  endgenerate

  // Per-register writeback select; later slots override earlier ones.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_wb
      if (gi == 0) begin : g_zero
        assign regs_next[gi] = '0;
      end else begin : g_sel
        logic [31:0] nxt;
        always_comb begin
          nxt = regs_reg[gi];
          for (int s = 0; s < NSLOTS; s++) begin
            if (wen[s] && (rd_f[s] == 5'(gi))) begin
              nxt = res[s];
            end
          end
        end
        assign regs_next[gi] = nxt;
      end
    end
  endgenerate

  always_comb begin
    pc_next     = pc_reg + IMEM_AW'(1);
    halted_next = |halt_en;
    for (int s = 0; s < NSLOTS; s++) begin
      if (jmp_en[s]) begin
        pc_next = jmp_tgt[s];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg     <= '0;
      halted_reg <= 1'b0;
      for (int r = 0; r < 32; r++) begin
        regs_reg[r] <= '0;
      end
    end else if (!halted_reg) begin
      pc_reg     <= pc_next;
      halted_reg <= halted_next;
      for (int r = 0; r < 32; r++) begin
        regs_reg[r] <= regs_next[r];
      end
    end
  end

  // Data memory keeps its contents across reset; stores are simply blocked.
  always_ff @(posedge clk) begin
    if (!rst && !halted_reg) begin
      for (int s = 0; s < NSLOTS; s++) begin
        if (sw_en[s]) begin
          dmem[sw_addr[s]] <= sw_data[s];
        end
      end
    end
  end

  assign bus.dbg_rdata = regs_reg[bus.dbg_raddr];
  assign bus.pc        = pc_reg;
  assign bus.halted    = halted_reg;
endmodule

// File: tb/tb_vliw_processor.sv
// Directed program walk-through plus a randomized run compared against a
// bundle-level reference model of the VLIW core.
module tb_vliw_processor;
  localparam int AW = 8;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b01001;
  localparam logic [4:0] OP_SUB  = 5'b01010;
  localparam logic [4:0] OP_AND  = 5'b01011;
  localparam logic [4:0] OP_OR   = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_SLL  = 5'b01110;
  localparam logic [4:0] OP_SRL  = 5'b01111;
  localparam logic [4:0] OP_SLT  = 5'b10000;
  localparam logic [4:0] OP_LI   = 5'b10100;
  localparam logic [4:0] OP_ADDI = 5'b10101;
  localparam logic [4:0] OP_LW   = 5'b11000;
  localparam logic [4:0] OP_SW   = 5'b11001;
  localparam logic [4:0] OP_JMP  = 5'b11110;
  localparam logic [4:0] OP_HALT = 5'b11111;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  vliw_processor_if #(.IMEM_AW(AW)) bus();

  vliw_processor #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [319:0] img      [256];
  logic [319:0] ref_imem [256];
  logic [31:0]  m_regs   [32];
  logic [31:0]  m_dmem   [256];
  logic [7:0]   m_pc;
  logic         m_halted;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
    bus.dbg_raddr = 5'(idx);
    #1;
    check_val(tag, bus.dbg_rdata, exp);
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(logic [4:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {op, rd, rs1, rs2, 12'h000};
  endfunction

  function automatic logic [31:0] enc_i22(logic [4:0] op, logic [4:0] rd, logic [21:0] imm);
    return {op, rd, imm};
  endfunction

  function automatic logic [31:0] enc_i17(logic [4:0] op, logic [4:0] rd, logic [4:0] rs1, logic [16:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic put_slot(input int addr, input int k, input logic [31:0] s);
    img[addr][32*k +: 32] = s;
  endtask

  task automatic load_image();
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      bus.imem_we    = 1'b1;
      bus.imem_waddr = 8'(a);
      bus.imem_wdata = img[a];
      ref_imem[a]    = img[a];
    end
    @(negedge clk);
    bus.imem_we = 1'b0;
  endtask

  function automatic logic [31:0] rand_slot();
    logic [4:0]  ops [14] = '{OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL,
                              OP_SRL, OP_SLT, OP_LI, OP_ADDI, OP_LW, OP_SW, 5'b00011};
    logic [31:0] r = $urandom();
    int          p = $urandom_range(0, 999);
    logic [4:0]  op;
    if (p == 0)       op = OP_HALT;
    else if (p < 30)  op = OP_JMP;
    else if (p < 250) op = OP_LI;
    else              op = ops[$urandom_range(0, 13)];
    return {op, r[26:0]};
  endfunction

  function automatic logic [319:0] rand_bundle();
    logic [319:0] b;
    for (int s = 0; s < 10; s++) b[32*s +: 32] = rand_slot();
    return b;
  endfunction

  // Executes one bundle: reads from a snapshot, stages stores, commits all at once.
  task automatic model_step();
    logic [319:0] bw;
    logic [31:0]  old_r [32];
    logic [31:0]  new_r [32];
    logic [7:0]   st_addr [$];
    logic [31:0]  st_data [$];
    logic [7:0]   npc;
    logic         hlt;
    if (m_halted) return;
    bw    = ref_imem[m_pc];
    old_r = m_regs;
    new_r = m_regs;
    npc   = m_pc + 8'd1;
    hlt   = 1'b0;
    for (int s = 0; s < 10; s++) begin
      logic [31:0] sl, a, b, i22, i17, ea;
      logic [4:0]  rd;
      sl  = bw[32*s +: 32];
      rd  = sl[26:22];
      a   = old_r[sl[21:17]];
      b   = old_r[sl[16:12]];
      i22 = {{10{sl[21]}}, sl[21:0]};
      i17 = {{15{sl[16]}}, sl[16:0]};
      ea  = a + i17;
      case (sl[31:27])
        OP_ADD:  new_r[rd] = a + b;
        OP_SUB:  new_r[rd] = a - b;
        OP_AND:  new_r[rd] = a & b;
        OP_OR:   new_r[rd] = a | b;
        OP_XOR:  new_r[rd] = a ^ b;
        OP_SLL:  new_r[rd] = a << b[4:0];
        OP_SRL:  new_r[rd] = a >> b[4:0];
        OP_SLT:  new_r[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        OP_LI:   new_r[rd] = i22;
        OP_ADDI: new_r[rd] = ea;
        OP_LW:   new_r[rd] = m_dmem[ea[7:0]];
        OP_SW:   begin st_addr.push_back(ea[7:0]); st_data.push_back(old_r[rd]); end
        OP_JMP:  npc = i22[7:0];
        OP_HALT: hlt = 1'b1;
        default: ;
      endcase
    end
    foreach (st_addr[i]) m_dmem[st_addr[i]] = st_data[i];
    new_r[0] = 32'd0;
    m_regs   = new_r;
    m_pc     = npc;
    m_halted = hlt;
  endtask

  initial begin
    rst            = 1'b1;
    bus.imem_we    = 1'b0;
    bus.imem_waddr = '0;
    bus.imem_wdata = '0;
    bus.dbg_raddr  = '0;

    // ---------------- directed program ----------------
    for (int a = 0; a < 256; a++) img[a] = '0;
    put_slot(0,    9, enc_i17(OP_LW, 5'd12, 5'd0, 17'd10));
    put_slot(1,    0, enc_i22(OP_LI, 5'd2, 22'd4));
    put_slot(2,    0, enc_i22(OP_LI, 5'd3, 22'd5));
    put_slot(3,    4, enc_r(OP_ADD, 5'd4, 5'd2, 5'd3));
    put_slot(4,    1, enc_i22(OP_LI, 5'd5, 22'd7));
    put_slot(4,    8, enc_i22(OP_LI, 5'd5, 22'd9));
    put_slot(4,    2, enc_i22(OP_LI, 5'd0, 22'd3));
    put_slot(5,    0, enc_i22(OP_LI, 5'd1, 22'h3FFFFF));
    put_slot(6,    0, enc_i17(OP_ADDI, 5'd6, 5'd1, 17'd2));
    put_slot(6,    5, enc_r(OP_SUB, 5'd7, 5'd0, 5'd1));
    put_slot(7,    0, enc_i17(OP_SW, 5'd0, 5'd0, 17'd10));
    put_slot(8,    2, enc_i17(OP_SW, 5'd2, 5'd0, 17'd10));
    put_slot(8,    6, enc_i17(OP_LW, 5'd8, 5'd0, 17'd10));
    put_slot(9,    0, enc_i17(OP_LW, 5'd9, 5'd0, 17'd10));
    put_slot(10,   3, enc_i22(OP_JMP, 5'd0, 22'h20));
    put_slot(8'h20, 1, enc_i22(OP_LI, 5'd10, 22'd1));
    put_slot(8'h20, 9, enc_i22(OP_HALT, 5'd0, 22'd0));
    put_slot(8'h21, 0, enc_i22(OP_LI, 5'd11, 22'h55));
    load_image();

    check_val("reset_pc", 32'(bus.pc), 32'd0);
    check_val("reset_halted", 32'(bus.halted), 32'd0);
    check_reg("reset_r2", 2, 32'd0);
    rst = 1'b0;

    step_edge(); check_val("pc_e1", 32'(bus.pc), 32'd1);
    $display("edge 1: pc=%0h", bus.pc);
    step_edge(); check_val("pc_e2", 32'(bus.pc), 32'd2); check_reg("li_r2", 2, 32'd4);
    step_edge(); check_val("pc_e3", 32'(bus.pc), 32'd3); check_reg("li_r3", 3, 32'd5);
    step_edge(); check_val("pc_e4", 32'(bus.pc), 32'd4); check_reg("add_r4", 4, 32'd9);
    step_edge(); check_reg("waw_r5", 5, 32'd9); check_reg("r0_zero", 0, 32'd0);
    step_edge(); check_reg("li_neg_r1", 1, 32'hFFFFFFFF);
    step_edge(); check_reg("addi_r6", 6, 32'd1); check_reg("sub_r7", 7, 32'd1);
    step_edge();
    step_edge(); check_reg("lw_old_r8", 8, 32'd0);
    step_edge(); check_reg("lw_new_r9", 9, 32'd4); check_val("pc_e10", 32'(bus.pc), 32'd10);
    step_edge(); check_val("jmp_pc", 32'(bus.pc), 32'h20);
    check_val("pre_halt", 32'(bus.halted), 32'd0);
    step_edge(); check_reg("halt_r10", 10, 32'd1);
    check_val("halted", 32'(bus.halted), 32'd1);
    check_val("halt_pc", 32'(bus.pc), 32'h21);
    $display("halt: pc=%0h halted=%0b", bus.pc, bus.halted);
    for (int i = 0; i < 12; i++) begin
      step_edge();
      check_val("frozen_pc", 32'(bus.pc), 32'h21);
      check_val("frozen_halted", 32'(bus.halted), 32'd1);
    end
    check_reg("frozen_r11", 11, 32'd0);

    // Asynchronous reset in the middle of a clock period.
    @(posedge clk); #3; rst = 1'b1; #1;
    check_val("arst_pc", 32'(bus.pc), 32'd0);
    check_val("arst_halted", 32'(bus.halted), 32'd0);
    for (int r = 2; r <= 10; r++) check_reg($sformatf("arst_r%0d", r), r, 32'd0);
    @(negedge clk); rst = 1'b0;
    step_edge(); check_reg("dmem_kept_r12", 12, 32'd4); check_val("rerun_pc", 32'(bus.pc), 32'd1);
    repeat (4) step_edge();
    @(posedge clk); #3; rst = 1'b1; #1;
    check_val("arst2_pc", 32'(bus.pc), 32'd0);
    check_reg("arst2_r5", 5, 32'd0);
    check_reg("arst2_r12", 12, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (12) step_edge();
    check_reg("rerun_r4", 4, 32'd9);
    check_reg("rerun_r8", 8, 32'd0);
    check_reg("rerun_r9", 9, 32'd4);
    check_reg("rerun_r10", 10, 32'd1);
    check_reg("rerun_r12", 12, 32'd4);
    check_val("rerun_halted", 32'(bus.halted), 32'd1);
    check_val("rerun_pc", 32'(bus.pc), 32'h21);
    $display("rerun: pc=%0h halted=%0b", bus.pc, bus.halted);

    // ---------------- randomized run against the model ----------------
    @(negedge clk); rst = 1'b1;
    for (int b = 0; b < 26; b++) begin
      img[b] = '0;
      for (int s = 0; s < 10; s++) begin
        if (b * 10 + s < 256) put_slot(b, s, enc_i17(OP_SW, 5'd0, 5'd0, 17'(b * 10 + s)));
      end
    end
    for (int a = 26; a < 256; a++) img[a] = rand_bundle();
    load_image();
    for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
    m_pc     = 8'd0;
    m_halted = 1'b0;
    check_val("rnd_reset_pc", 32'(bus.pc), 32'd0);
    rst = 1'b0;

    for (int cyc = 0; cyc < 300; cyc++) begin
      logic         wr;
      logic [7:0]   wa;
      logic [319:0] wd;
      int           ridx;
      wr = ($urandom_range(0, 7) == 0);
      wa = (m_pc >= 8'd26 && $urandom_range(0, 1) == 1) ? m_pc : 8'($urandom_range(26, 255));
      wd = rand_bundle();
      bus.imem_we    = wr;
      bus.imem_waddr = wa;
      bus.imem_wdata = wd;
      @(posedge clk);
      model_step();
      if (wr) ref_imem[wa] = wd;
      #1;
      check_val("rnd_pc", 32'(bus.pc), 32'(m_pc));
      check_val("rnd_halted", 32'(bus.halted), 32'(m_halted));
      ridx = cyc % 32;
      check_reg($sformatf("rnd_r%0d", ridx), ridx, m_regs[ridx]);
      ridx = $urandom_range(0, 31);
      check_reg($sformatf("rnd_r%0d", ridx), ridx, m_regs[ridx]);
      $display("cyc %0d: pc=%0h halted=%0b imem_we=%0b", cyc, bus.pc, bus.halted, wr);
      @(negedge clk);
    end
    bus.imem_we = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
